// File: rtl/decode_issue.sv
// Decode/issue stage: decodes RV32I OP, OP-IMM and LUI into an op/in1/in2 triple for exec,
// with a busy-register scoreboard against RAW hazards and a one-entry registered output.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  op,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_SLL  = 6'd2;
    localparam logic [5:0] OP_SLT  = 6'd3;
    localparam logic [5:0] OP_SLTU = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SRL  = 6'd6;
    localparam logic [5:0] OP_SRA  = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8;
    localparam logic [5:0] OP_AND  = 6'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state, state_next;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  dst;
    logic        legal, use_rs1, use_rs2, hazard, accept;
    logic [5:0]  dec_op;
    logic [31:0] dec_in1, dec_in2;
    logic [31:0] busy, busy_next;

    assign opcode   = instr[6:0];
    assign dst      = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [5:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? OP_SUB : OP_ADD;
            3'b001:  alu_op = OP_SLL;
            3'b010:  alu_op = OP_SLT;
            3'b011:  alu_op = OP_SLTU;
            3'b100:  alu_op = OP_XOR;
            3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
            3'b110:  alu_op = OP_OR;
            default: alu_op = OP_AND;
        endcase
    endfunction

    // Anything not recognised falls through to the bubble values (ADD, 0, 0)
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_op  = OP_ADD;
        dec_in1 = '0;
        dec_in2 = '0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    legal   = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    dec_op  = alu_op(funct3, funct7[5]);
                    dec_in1 = rs1_data;
                    dec_in2 = rs2_data;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct7 == F7_ZERO || (funct7 == F7_ALT && funct3 == 3'b101)) begin
                        legal   = 1'b1;
                        use_rs1 = 1'b1;
                        dec_op  = alu_op(funct3, funct7[5]);
                        dec_in1 = rs1_data;
                        dec_in2 = {27'd0, instr[24:20]};
                    end
                end else begin
                    legal   = 1'b1;
                    use_rs1 = 1'b1;
                    dec_op  = alu_op(funct3, 1'b0);
                    dec_in1 = rs1_data;
                    dec_in2 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                dec_in2 = {instr[31:12], 12'd0};
            end
            default: ;
        endcase
    end

    // Illegal instructions never stall, so the hazard is qualified by legality
    assign hazard    = legal && ((use_rs1 && busy[rs1_addr]) || (use_rs2 && busy[rs2_addr]));
    assign out_valid = (state == FULL);
    assign in_ready  = (!out_valid || out_ready) && !(in_valid && hazard);
    assign accept    = in_valid && in_ready;

    // Set is applied after clear so a same-index set wins
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_rd] = 1'b0;
        if (accept && legal && dst != 5'd0)
            busy_next[dst] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            busy  <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= 6'd0;
            in1     <= '0;
            in2     <= '0;
            rd      <= '0;
            illegal <= 1'b0;
        end else if (accept) begin
            op      <= dec_op;
            in1     <= dec_in1;
            in2     <= dec_in2;
            rd      <= legal ? dst : 5'd0;
            illegal <= !legal;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: expected issue slots are queued at accept and
// compared when the slot appears on the output.
module tb_decode_issue;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_SLL  = 6'd2;
    localparam logic [5:0] OP_SLT  = 6'd3;
    localparam logic [5:0] OP_SLTU = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SRL  = 6'd6;
    localparam logic [5:0] OP_SRA  = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8;
    localparam logic [5:0] OP_AND  = 6'd9;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] d1;
        logic [31:0] d2;
        exp_t        e;
    } vec_t;

    logic        clk, rst, in_valid, in_ready, wb_valid, out_valid, out_ready, illegal;
    logic [31:0] instr, rs1_data, rs2_data, in1, in2;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd, rd;
    logic [5:0]  op;

    exp_t        exp_q[$];
    vec_t        tbl[$];
    logic [31:0] exp_busy;
    int          total = 0;
    int          bad = 0;

    decode_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .in1(in1), .in2(in2), .rd(rd), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $error("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] r, input logic il);
        exp_t e;
        e.op = o; e.in1 = a; e.in2 = b; e.rd = r; e.ill = il;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] d1,
                                 input logic [31:0] d2, input exp_t e);
        vec_t v;
        v.ins = ins; v.d1 = d1; v.d2 = d2; v.e = e;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = d1;
        rs2_data = d2;
    endtask

    // Called away from the edge; returns one step after the accepting edge
    task automatic acceptWait(input exp_t e);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $error("[TB] FAIL accept_timeout observed=in_ready 0 expected=1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        if (!e.ill && e.rd != 5'd0)
            exp_busy[e.rd] = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("op", {26'd0, op}, {26'd0, e.op});
        check("in1", in1, e.in1);
        check("in2", in2, e.in2);
        check("rd", {27'd0, rd}, {27'd0, e.rd});
        check("illegal", {31'd0, illegal}, {31'd0, e.ill});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b1; exp_busy = '0;

        tbl.push_back(mkv(32'hfff02493, 0, 0, mk(OP_SLT,  0, 32'hffffffff, 9, 0)));
        tbl.push_back(mkv(32'h00703493, 0, 0, mk(OP_SLTU, 0, 32'h7, 9, 0)));
        tbl.push_back(mkv(32'h80004493, 0, 0, mk(OP_XOR,  0, 32'hfffff800, 9, 0)));
        tbl.push_back(mkv(32'h7ff06493, 0, 0, mk(OP_OR,   0, 32'h7ff, 9, 0)));
        tbl.push_back(mkv(32'h0f007493, 0, 0, mk(OP_AND,  0, 32'hf0, 9, 0)));
        tbl.push_back(mkv(32'h00401493, 0, 0, mk(OP_SLL,  0, 32'h4, 9, 0)));
        tbl.push_back(mkv(32'h01f05493, 0, 0, mk(OP_SRL,  0, 32'h1f, 9, 0)));
        tbl.push_back(mkv(32'h40401493, 0, 0, mk(OP_ADD,  0, 0, 0, 1)));
        tbl.push_back(mkv(32'h00c58533, 32'h11, 32'h22, mk(OP_ADD,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c59533, 32'h11, 32'h22, mk(OP_SLL,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5a533, 32'h11, 32'h22, mk(OP_SLT,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5b533, 32'h11, 32'h22, mk(OP_SLTU, 32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5c533, 32'h11, 32'h22, mk(OP_XOR,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5d533, 32'h11, 32'h22, mk(OP_SRL,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h40c5d533, 32'h11, 32'h22, mk(OP_SRA,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5e533, 32'h11, 32'h22, mk(OP_OR,   32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h00c5f533, 32'h11, 32'h22, mk(OP_AND,  32'h11, 32'h22, 10, 0)));
        tbl.push_back(mkv(32'h40c59533, 32'h11, 32'h22, mk(OP_ADD,  0, 0, 0, 1)));
        tbl.push_back(mkv(32'h022081b3, 32'h11, 32'h22, mk(OP_ADD,  0, 0, 0, 1)));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op", {26'd0, op}, 32'd0);
        check("rst_in1", in1, 32'd0);
        check("rst_in2", in2, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", dut.busy, exp_busy);

        // ADDI x1,x0,5
        @(posedge clk); #1;
        applyStimulus(32'h00500093, 0, 0);
        @(negedge clk);
        acceptWait(mk(OP_ADD, 0, 5, 1, 0));
        @(negedge clk);
        checkOutput();
        check("addi_busy", dut.busy, exp_busy);

        // ADD x2,x1,x1 stalls until x1 is written back
        applyStimulus(32'h00108133, 5, 5);
        #1 check("raw_stall_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("raw_stall_ready2", {31'd0, in_ready}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd1;
        @(posedge clk); #1;
        wb_valid = 1'b0; exp_busy[1] = 1'b0;
        @(negedge clk);
        check("raw_release_ready", {31'd0, in_ready}, 32'd1);
        acceptWait(mk(OP_ADD, 5, 5, 2, 0));
        @(negedge clk);
        checkOutput();
        wb_valid = 1'b1; wb_rd = 5'd2;
        @(posedge clk); #1;
        wb_valid = 1'b0; exp_busy[2] = 1'b0;

        // SUB x3,x1,x2 then held for 3 cycles while LUI waits behind it
        applyStimulus(32'h402081b3, 7, 2);
        @(negedge clk);
        acceptWait(mk(OP_SUB, 7, 2, 3, 0));
        out_ready = 1'b0;
        applyStimulus(32'h123453b7, 32'hdead, 32'hbeef);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_op", {26'd0, op}, {26'd0, exp_q[0].op});
            check("hold_in1", in1, exp_q[0].in1);
            check("hold_in2", in2, exp_q[0].in2);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            if (i == 0) begin
                wb_valid = 1'b1; wb_rd = 5'd3; rs1_data = 32'd99; exp_busy[3] = 1'b0;
            end else begin
                wb_valid = 1'b0;
            end
        end
        checkOutput();
        out_ready = 1'b1;
        #1 check("lui_ready", {31'd0, in_ready}, 32'd1);
        acceptWait(mk(OP_ADD, 0, 32'h12345000, 7, 0));

        // SRAI x5,x6,3 back to back, then an illegal word
        applyStimulus(32'h40335293, 32'h80000000, 0);
        @(negedge clk);
        checkOutput();
        check("srai_b2b_ready", {31'd0, in_ready}, 32'd1);
        acceptWait(mk(OP_SRA, 32'h80000000, 3, 5, 0));
        applyStimulus(32'hffffffff, 0, 0);
        @(negedge clk);
        checkOutput();
        acceptWait(mk(OP_ADD, 0, 0, 0, 1));
        @(negedge clk);
        checkOutput();
        check("illegal_busy", dut.busy, exp_busy);

        // Illegal word naming busy x5 as rs1 must not stall
        applyStimulus(32'h00028000, 0, 0);
        #1 check("illegal_nostall", {31'd0, in_ready}, 32'd1);
        acceptWait(mk(OP_ADD, 0, 0, 0, 1));
        @(negedge clk);
        checkOutput();

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].ins, tbl[i].d1, tbl[i].d2);
            @(negedge clk);
            if (exp_q.size() != 0) checkOutput();
            acceptWait(tbl[i].e);
        end
        @(negedge clk);
        checkOutput();
        @(negedge clk);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("table_busy", dut.busy, exp_busy);

        // ADDI x4,x0,1 accepted in the same cycle as a writeback of x4
        applyStimulus(32'h00100213, 0, 0);
        wb_valid = 1'b1; wb_rd = 5'd4; exp_busy[4] = 1'b0;
        #1;
        acceptWait(mk(OP_ADD, 0, 1, 4, 0));
        wb_valid = 1'b0;
        @(negedge clk);
        checkOutput();
        check("simul_busy", dut.busy, exp_busy);
        applyStimulus(32'h00020433, 0, 0);
        #1 check("simul_hazard_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Asynchronous reset while an operation is held
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(32'habcde5b7, 0, 0);
        @(negedge clk);
        acceptWait(mk(OP_ADD, 0, 32'habcde000, 11, 0));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in2", in2, 32'd0);
        check("arst_rd", {27'd0, rd}, 32'd0);
        check("arst_busy", dut.busy, 32'd0);
        exp_q.delete();
        exp_busy = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_release_ready", {31'd0, in_ready}, 32'd1);
        check("arst_release_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage that produces the `op`/`in1`/`in2` operand triple consumed by `exec`. It takes 32-bit RV32I integer instruction words over a valid/ready handshake and reads source registers through combinational register-file read ports. A busy-register scoreboard blocks read-after-write hazards. One decoded operation per cycle is registered toward `exec` with its own valid/ready handshake.

## Interface
- No parameters; data width fixed at 32, register index 5 bits, op 6 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: instruction accepted on a cycle where `in_valid && in_ready`.
- `instr` input 32: instruction word.
- `rs1_addr`, `rs2_addr` output 5 each: register-file read addresses, combinational from `instr[19:15]` and `instr[24:20]`.
- `rs1_data`, `rs2_data` input 32 each: register-file read data, same cycle; x0 reads 0.
- `wb_valid` input 1: writeback of `wb_rd` completes this cycle; the register file holds the new value from the next cycle.
- `wb_rd` input 5: destination being written back.
- `out_valid` output 1: decoded operation valid toward `exec`.
- `out_ready` input 1: downstream accepts on `out_valid && out_ready`.
- `op` output 6: `constants.v` operation code. `ADD`, `SUB`, `SLL`, `SLT`, `SLTU`, `XOR`, `SRL`, `SRA`, `OR`, `AND` are added there as needed.
- `in1`, `in2` output 32: operands.
- `rd` output 5: destination register.
- `illegal` output 1: the issued slot is an illegal instruction.

## Operation
- Supported opcodes:
  - OP `0110011`: `in1` = `rs1_data`, `in2` = `rs2_data`.
  - OP-IMM `0010011`: `in1` = `rs1_data`, `in2` = sign-extended `instr[31:20]`. For SLLI/SRLI/SRAI, `in2` = zero-extended `instr[24:20]`.
  - LUI `0110111`: `op`=`ADD`, `in1`=0, `in2`={`instr[31:12]`,12'b0}.
- funct3 mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - SUB only for OP with funct7 `0100000`.
  - SRA/SRAI with funct7 `0100000`.
  - Any other funct7 on OP, or on OP-IMM shifts, is illegal.
- Illegal instruction (any other opcode or bad funct7):
  - Issued as a bubble: `illegal`=1, `op`=`ADD`, `in1`=`in2`=0, `rd`=0.
  - No scoreboard update.
  - Never stalls on hazards.
- Source usage: OP reads rs1 and rs2; OP-IMM reads rs1 only; LUI reads neither.
- Scoreboard: 32-bit `busy` register; bit 0 is never set.
  - `hazard` = (uses rs1 && `busy[rs1]`) || (uses rs2 && `busy[rs2]`).
  - On accept of a legal instruction with rd≠0, set `busy[rd]`.
  - `wb_valid` clears `busy[wb_rd]`.
  - Set and clear of the same index in the same cycle: set wins.
  - No bypass. An instruction stalled on `busy[r]` is accepted in the cycle after `wb_valid` for r.
- `in_ready` = (!`out_valid` || `out_ready`) && !(`in_valid` && `hazard`).
- FSM, output register state:
  - EMPTY: `out_valid`=0. Accept → FULL.
  - FULL: `out_valid`=1.
    - `out_ready` with no accept → EMPTY.
    - `out_ready` with accept → FULL, registers reload.
    - `out_ready`=0 → hold.

## Timing
- Reset values: `out_valid`=0, `op`=6'd0, `in1`=0, `in2`=0, `rd`=0, `illegal`=0, `busy`=0. FSM is in EMPTY.
- Reset asserted mid-operation drops any held operation and clears the scoreboard immediately; there is no pending writeback tracking.
- `in_ready` is 1 in the first cycle after reset deasserts when there is no hazard.
- Latency: accept in cycle N → `out_valid` with the decoded fields in cycle N+1.
- Throughput: 1 per cycle with `out_ready` held high and no hazards.
- `op`, `in1`, `in2`, `rd`, `illegal` stay stable while `out_valid && !out_ready`.
- Operands are sampled at accept; a later writeback does not alter a held output.
- `rs*_addr` decode is purely combinational; `in_ready` does not depend on `out_valid` of the next cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs at reset values immediately. After release with `in_valid`=0, `in_ready`=1.
- ADDI x1,x0,5 (`0x00500093`), `rs1_data`=0 → next cycle `out_valid`=1, `op`=`ADD`, `in1`=0, `in2`=5, `rd`=1, `busy[1]`=1.
- RAW stall: after the previous instruction, present ADD x2,x1,x1 (`0x00108133`) → `in_ready`=0. Pulse `wb_valid` with `wb_rd`=1 → accepted the following cycle, `rd`=2.
- SUB x3,x1,x2 (`0x402081b3`), `rs1_data`=7, `rs2_data`=2 → `op`=`SUB`, `in1`=7, `in2`=2. With `out_ready`=0 for 3 cycles, outputs hold and `in_ready`=0.
- SRAI x5,x6,3 (`0x40335293`) → `op`=`SRA`, `in2`=3. Then `0xffffffff` → `illegal`=1, `rd`=0, `busy` unchanged.
- Simultaneous events: accept ADDI x4,x0,1 (`0x00100213`) with `wb_valid`/`wb_rd`=4 in the same cycle → `busy[4]` remains 1.
